// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: filtered PS/2 receiver with frame checking, prefix folding and output FIFO
`timescale 1ns/1ps
module ps2_keyboard_rx #(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 5000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          ps2_clk_i,
    input  logic                          ps2_data_i,
    output logic [7:0]                    code_o,
    output logic                          ext_o,
    output logic                          break_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          parity_err_o,
    output logic                          frame_err_o,
    output logic                          overflow_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_PAR  = 2'd2;
    localparam logic [1:0] ST_STOP = 2'd3;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall;
    logic [1:0]    state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic          perr, ferr, byte_ok, push;
    logic          perr_q, ferr_q, ovf_q;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [9:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop, full, we, ovf;

    // Deglitch: the filtered clock follows the synchronised clock only after FILTER_LEN disagreeing cycles
    always_comb begin
        fcnt_d = '0;
        filt_d = filt_q;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
            else fcnt_d = fcnt_q + 1'b1;
        end
        fall = filt_q & ~filt_d;
    end

    // Frame deserialiser, timeout watchdog and E0/F0 prefix tracking
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tcnt_d  = (state_q == ST_IDLE) ? '0 : tcnt_q + 1'b1;
        ext_d   = ext_q;
        brk_d   = brk_q;
        perr    = 1'b0;
        ferr    = 1'b0;
        byte_ok = 1'b0;
        push    = 1'b0;
        if (fall) begin
            tcnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    ferr    = dat_s2_q;
                    state_d = dat_s2_q ? ST_IDLE : ST_DATA;
                    bit_d   = 3'd0;
                end
                ST_DATA: begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    state_d = (bit_q == 3'd7) ? ST_PAR : ST_DATA;
                end
                ST_PAR: begin
                    par_d   = dat_s2_q;
                    state_d = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                    perr    = ~(^{shift_q, par_q});
                    ferr    = ~dat_s2_q;
                    byte_ok = (^{shift_q, par_q}) & dat_s2_q;
                end
            endcase
        end else if (state_q != ST_IDLE && tcnt_q == TW'(TIMEOUT - 1)) begin
            state_d = ST_IDLE;
            tcnt_d  = '0;
            ferr    = 1'b1;
        end
        if (perr | ferr) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
        if (byte_ok) begin
            if (shift_q == 8'hE0) ext_d = 1'b1;
            else if (shift_q == 8'hF0) brk_d = 1'b1;
            else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    // FIFO bookkeeping: a push while full only lands if the head leaves in the same cycle
    always_comb begin
        pop     = valid_o & ready_i;
        full    = count_q == CW'(FIFO_DEPTH);
        we      = push & (~full | pop);
        ovf     = push & full & ~pop;
        mem_d   = mem_q;
        if (we) mem_d[wr_q] = {ext_q, brk_q, shift_q};
        wr_d    = we ? wr_q + 1'b1 : wr_q;
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        count_d = count_q + CW'(we) - CW'(pop);
    end

    // All state registers, cleared asynchronously; idle lines and filter rest high
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
            state_q  <= ST_IDLE;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tcnt_q   <= '0;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovf_q    <= 1'b0;
            mem_q    <= '{default: '0};
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
        end else begin
            clk_s1_q <= ps2_clk_i;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data_i;
            dat_s2_q <= dat_s1_q;
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
            state_q  <= state_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tcnt_q   <= tcnt_d;
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            perr_q   <= perr;
            ferr_q   <= ferr;
            ovf_q    <= ovf;
            mem_q    <= mem_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
        end
    end

    assign valid_o      = count_q != '0;
    assign code_o       = valid_o ? mem_q[rd_q][7:0] : 8'h00;
    assign break_o      = valid_o & mem_q[rd_q][8];
    assign ext_o        = valid_o & mem_q[rd_q][9];
    assign fifo_count_o = count_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign overflow_o   = ovf_q;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: random and directed PS/2 frames checked against a frame-level decode model
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;
    localparam int FL    = 4;
    localparam int TO    = 5000;
    localparam int DEPTH = 8;
    localparam int HALF  = 20;

    logic       clk_i = 1'b0, rst_i = 1'b1, ps2_clk_i = 1'b1, ps2_data_i = 1'b1, ready_i = 1'b0;
    logic [7:0] code_o;
    logic       ext_o, break_o, valid_o, parity_err_o, frame_err_o, overflow_o;
    logic [3:0] fifo_count_o;

    ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT(TO), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
        .code_o(code_o), .ext_o(ext_o), .break_o(break_o), .valid_o(valid_o), .ready_i(ready_i),
        .fifo_count_o(fifo_count_o), .parity_err_o(parity_err_o), .frame_err_o(frame_err_o),
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0, bad = 0;
    int n_perr = 0, n_ferr = 0, n_ovf = 0;
    int exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
    logic [9:0] obs_q[$];
    logic [9:0] exp_q[$];
    int obs_rd = 0, exp_rd = 0, held = 0;
    logic m_ext = 1'b0, m_brk = 1'b0;

    // Observe everything leaving the FIFO and every pulse cycle, away from the rising edge
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (valid_o && ready_i) obs_q.push_back({ext_o, break_o, code_o});
            if (parity_err_o) n_perr++;
            if (frame_err_o) n_ferr++;
            if (overflow_o) n_ovf++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send_bits(input logic [10:0] b, input int n, input int g);
        for (int i = 0; i < n; i++) begin
            ps2_data_i = b[i];
            if (g > 0) begin
                tick(3);
                ps2_clk_i = 1'b0;
                tick(g);
                ps2_clk_i = 1'b1;
                tick(HALF / 2 - 3 - g);
            end else tick(HALF / 2);
            ps2_clk_i = 1'b0;
            tick(HALF);
            ps2_clk_i = 1'b1;
            tick(HALF / 2);
        end
        ps2_data_i = 1'b1;
    endtask

    task automatic model_frame(input logic [7:0] d, input bit par_ok, input bit stop_ok);
        if (!par_ok) exp_perr++;
        if (!stop_ok) exp_ferr++;
        if (!par_ok || !stop_ok) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (d == 8'hE0) m_ext = 1'b1;
        else if (d == 8'hF0) m_brk = 1'b1;
        else begin
            if (!ready_i && held == DEPTH) exp_ovf++;
            else begin
                exp_q.push_back({m_ext, m_brk, d});
                if (!ready_i) held++;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop, input int g);
        logic p;
        p = (~^d) ^ bad_par;
        send_bits({~bad_stop, p, d, 1'b0}, 11, g);
        tick(20);
        model_frame(d, !bad_par, !bad_stop);
    endtask

    task automatic checkpoint(input string tag);
        check({tag, "_perr"}, n_perr, exp_perr);
        check({tag, "_ferr"}, n_ferr, exp_ferr);
        check({tag, "_ovf"}, n_ovf, exp_ovf);
        check({tag, "_entries"}, obs_q.size() - obs_rd, exp_q.size() - exp_rd);
        while (obs_rd < obs_q.size() && exp_rd < exp_q.size()) begin
            check($sformatf("%s_entry%0d", tag, exp_rd), obs_q[obs_rd], exp_q[exp_rd]);
            obs_rd++;
            exp_rd++;
        end
        obs_rd = obs_q.size();
        exp_rd = exp_q.size();
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        ready_i = 1'b1;
        while (valid_o && k < 100) begin
            tick(1);
            k++;
        end
        check({tag, "_drain_bound"}, k < 100, 1);
        tick(2);
        held = 0;
        check({tag, "_count_empty"}, fifo_count_o, 0);
    endtask

    initial begin
        tick(5);
        check("reset_outputs_during", {code_o, ext_o, break_o, valid_o, fifo_count_o,
              parity_err_o, frame_err_o, overflow_o}, 0);
        rst_i = 1'b0;
        tick(5);
        check("reset_outputs_after", {code_o, ext_o, break_o, valid_o, fifo_count_o,
              parity_err_o, frame_err_o, overflow_o}, 0);
        ready_i = 1'b1;

        send_frame(8'h1C, 0, 0, 0);
        checkpoint("plain_1c");

        send_frame(8'hE0, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h75, 0, 0, 0);
        send_frame(8'h75, 0, 0, 0);
        checkpoint("prefix_75");

        send_frame(8'h1C, 1, 0, 0);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h1C, 0, 1, 0);
        send_frame(8'h1C, 0, 0, 0);
        checkpoint("errors");

        send_frame(8'hE0, 0, 0, 0);
        send_bits({2'b11, 1'b0, 8'h5A, 1'b0}, 5, 0);
        tick(TO + 50);
        exp_ferr++;
        m_ext = 1'b0;
        m_brk = 1'b0;
        send_frame(8'h16, 0, 0, 0);
        checkpoint("timeout");

        tick(1);
        ready_i = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 0, 0, 0);
        check("ovf_count_full", fifo_count_o, DEPTH);
        check("ovf_head", code_o, 8'h01);
        check("ovf_pulses", n_ovf, exp_ovf);
        drain("ovf");
        checkpoint("ovf_order");

        send_frame(8'h2B, 0, 0, 2);
        send_frame(8'h4D, 0, 0, 1);
        checkpoint("glitch");

        ready_i = 1'b0;
        send_frame(8'h33, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0);
        send_bits({2'b11, 1'b0, 8'h1C, 1'b0}, 4, 0);
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("midreset_outputs", {code_o, ext_o, break_o, valid_o, fifo_count_o,
              parity_err_o, frame_err_o, overflow_o}, 0);
        repeat (held) void'(exp_q.pop_back());
        held = 0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        tick(3);
        rst_i = 1'b0;
        ready_i = 1'b1;
        tick(3);
        send_frame(8'h1C, 0, 0, 0);
        checkpoint("after_reset");

        for (int f = 0; f < 40; f++) begin
            int r, e;
            logic [7:0] d;
            r = $urandom_range(0, 5);
            d = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
            e = $urandom_range(0, 9);
            send_frame(d, e == 0 || e == 2, e == 1 || e == 2, $urandom_range(0, 2));
            checkpoint($sformatf("rand%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Parametrised PS/2 keyboard receiver: synchronises and deglitches the PS/2 clock/data lines, deframes 11-bit device-to-host frames with full start/parity/stop checking, and folds E0/F0 prefixes into make/break and extended flags. Decoded scancodes are buffered in an internal FIFO behind a valid/ready interface. It sits between the PS/2 connector pins and the keypad/display logic, replacing the unchecked single-digit receiver.

## Interface
- FILTER_LEN, 4: consecutive clk_i cycles the synchronised ps2_clk must hold a new level before it is accepted (≥2)
- TIMEOUT, 5000: clk_i cycles without a filtered falling edge that abort a partial frame
- FIFO_DEPTH, 8: entries in the output FIFO, power of two, ≥2
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- ps2_clk_i  in  1  raw PS/2 clock (asynchronous)
- ps2_data_i  in  1  raw PS/2 data (asynchronous)
- code_o  out  8  scancode at FIFO head (0 when empty)
- ext_o  out  1  head entry was preceded by E0
- break_o  out  1  head entry was preceded by F0 (key release)
- valid_o  out  1  FIFO not empty
- ready_i  in  1  consumer accepts head entry when valid_o && ready_i
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  entries held
- parity_err_o  out  1  one-cycle pulse: frame failed odd parity
- frame_err_o  out  1  one-cycle pulse: bad start/stop bit or timeout
- overflow_o  out  1  one-cycle pulse: decoded entry dropped, FIFO full

## Operation
- Reset: all outputs 0, FIFO empty, receiver IDLE, prefix flags clear, filtered clock = 1, synchronisers = 1.
- Both inputs pass a 2-FF synchroniser. Filtered clock changes on the FILTER_LEN-th consecutive edge where synchronised clock differs from it; any agreement resets the filter count. Data is sampled (synchronised value) on each filtered 1→0 transition.
- Receiver states: IDLE, DATA (8 bits, LSB first, bit counter 0..7), PARITY, STOP.
  - IDLE: sampled 0 → DATA; sampled 1 → stay IDLE, pulse frame_err_o.
  - DATA after bit 7 → PARITY → STOP → IDLE.
  - At STOP: parity error if XOR of 8 data bits and parity bit ≠ 1; frame error if stop bit ≠ 1. Both may pulse in the same cycle. Any error discards the byte and clears prefix flags.
- Timeout: in DATA/PARITY/STOP, a counter counts clk_i cycles since last filtered falling edge; reaching TIMEOUT → IDLE, pulse frame_err_o, discard partial byte, clear prefix flags. Counter held at 0 in IDLE.
- Decode of a good byte: E0 sets ext flag; F0 sets break flag; any other byte pushes {ext, break, byte} into the FIFO and clears both flags. Prefixes never enter the FIFO.
- FIFO: first-word fall-through, head drives code_o/ext_o/break_o. Pop on valid_o && ready_i. Push while full without simultaneous pop → entry dropped, overflow_o pulses, contents unchanged. Push and pop in the same cycle while full → both occur, count unchanged. Pop while empty ignored. Pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-frame or with FIFO data clears everything immediately; no pulse generated.

## Timing
- Edge latency: ps2_clk_i falling edge (clean input) is acted on at the (FILTER_LEN+2)-th rising clk_i edge after it.
- Push latency: valid_o / fifo_count_o update on that same edge for the stop bit; error pulses and overflow_o assert for exactly the one following cycle.
- Pop takes effect at the clk_i edge where valid_o && ready_i; next head visible the following cycle.
- Glitches on ps2_clk_i shorter than FILTER_LEN−1 cycles produce no edge.
- Sustained throughput: one entry per frame; consumer may hold ready_i low indefinitely.

## Test plan
- Frame 0x1C, parity 0, stop 1, ready_i=1 → valid_o one cycle with code_o=0x1C, ext_o=0, break_o=0, no error pulses.
- Sequence E0, F0, 0x75 → single entry code_o=0x75, ext_o=1, break_o=1; next plain 0x75 → ext_o=0, break_o=0.
- 0x1C with parity bit 1 → parity_err_o pulse, FIFO empty; following F0 then bad-stop 0x1C, then 0x1C → frame_err_o pulse, entry 0x1C with break_o=0.
- Stop clocking after 4 data bits for TIMEOUT cycles → frame_err_o pulse, state IDLE; subsequent valid 0x16 received correctly.
- ready_i=0, send FIFO_DEPTH+1 frames (0x01..0x09) → fifo_count_o=8, overflow_o pulse on 9th; draining yields 0x01..0x08 in order.
- 1-cycle glitch pulses on ps2_clk_i during a frame, and rst_i mid-frame → glitches ignored; after reset all outputs 0, next frame decoded cleanly.
